// File: rtl/vtg_pkg.sv
// Shared definitions for the raster timing generator.
// Holds the default 640x480@60 timing, the count width, the pixel colour
// type, the colour-bar palette and the axis-total helper.
// Optional feature macro used by the top: VTG_TEST_PATTERN_EN.
package vtg_pkg;

    localparam int unsigned COUNT_W   = 11;
    localparam int unsigned RGB_W     = 24;
    localparam int unsigned NUM_BARS  = 8;
    localparam int unsigned BAR_IDX_W = 3;

    // Default 640x480@60 timing
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BAR_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t BAR_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t BAR_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t BAR_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t BAR_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    localparam rgb_t BAR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t BAR_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_t BAR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

    // Period of one axis: active + front porch + sync + back porch
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Colour of bar idx, left to right
    function automatic rgb_t bar_colour(input logic [BAR_IDX_W-1:0] idx);
        rgb_t c;
        c = BAR_BLACK;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter with wrap and sync-region decode.
// Ports:
//   clock, reset      clock, async active-high reset
//   advance_i         step the position by one (wraps at TOTAL-1)
//   count_o           registered current position
//   count_next_c      position after this clock edge
//   wrap_c            current position is the last of the axis
//   active_next_c     next position lies in the active region
//   sync_o            registered sync pin level for the current position
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned FP       = DEF_H_FP,
    parameter int unsigned SYNC     = DEF_H_SYNC,
    parameter int unsigned BP       = DEF_H_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               advance_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [COUNT_W-1:0] count_next_c,
    output logic               wrap_c,
    output logic               active_next_c,
    output logic               sync_o
);

    localparam int unsigned        TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] ACTIVE_END = COUNT_W'(ACTIVE);
    localparam logic [COUNT_W-1:0] SYNC_START = COUNT_W'(ACTIVE + FP);
    localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(ACTIVE + FP + SYNC);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               sync_q;
    logic               sync_d;

    assign wrap_c = (count_q == LAST);

    // Next position and the decodes that describe it
    always_comb begin
        count_d = count_q;
        sync_d  = !SYNC_POL;
        if (advance_i) begin
            count_d = wrap_c ? '0 : count_q + COUNT_W'(1);
        end
        if ((count_d >= SYNC_START) && (count_d < SYNC_END)) begin
            sync_d = SYNC_POL;
        end
    end

    // Reset parks on the last position so the first advance lands on 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= LAST;
            sync_q  <= !SYNC_POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o       = count_q;
    assign count_next_c  = count_d;
    assign active_next_c = (count_d < ACTIVE_END);
    assign sync_o        = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: advances position on each pixel tick and
// produces registered sync, data-enable, coordinates and line/frame strobes.
// Optional colour bars when VTG_TEST_PATTERN_EN is defined (H_ACTIVE must be
// a multiple of 8); otherwise rgb_out is tied to 0.
// Ports:
//   clock, reset        clock, async active-high reset
//   tick_in             one-clock pixel tick
//   hcount_out          horizontal position 0..H_TOTAL-1
//   vcount_out          vertical position 0..V_TOTAL-1
//   hsync_out/vsync_out sync levels (active level = SYNC_POL)
//   de_out              active-area flag
//   line_start_out      strobe when hcount_out becomes 0
//   frame_start_out     strobe when position becomes (0,0)
//   rgb_out             pixel colour {R,G,B}
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_in,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out,
    output logic               line_start_out,
    output logic               frame_start_out,
    output logic [RGB_W-1:0]   rgb_out
);

    logic [COUNT_W-1:0] h_next;
    logic [COUNT_W-1:0] v_next;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_act_next;
    logic               v_act_next;
    logic               v_advance;
    logic               unused_c;

    logic de_q, de_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Vertical steps once per line, on the tick that wraps horizontal
    assign v_advance = tick_in && h_wrap;

    vtg_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clock         (clock),
        .reset         (reset),
        .advance_i     (tick_in),
        .count_o       (hcount_out),
        .count_next_c  (h_next),
        .wrap_c        (h_wrap),
        .active_next_c (h_act_next),
        .sync_o        (hsync_out)
    );

    vtg_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clock         (clock),
        .reset         (reset),
        .advance_i     (v_advance),
        .count_o       (vcount_out),
        .count_next_c  (v_next),
        .wrap_c        (v_wrap),
        .active_next_c (v_act_next),
        .sync_o        (vsync_out)
    );

    // Decodes of the next position; strobes only on an advancing tick
    always_comb begin
        de_d          = h_act_next && v_act_next;
        line_start_d  = tick_in && h_wrap;
        frame_start_d = tick_in && h_wrap && v_wrap;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de_out          = de_q;
    assign line_start_out  = line_start_q;
    assign frame_start_out = frame_start_q;

`ifdef VTG_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

    logic [BAR_IDX_W-1:0] bar_idx_c;
    rgb_t                 rgb_q;
    rgb_t                 rgb_d;

    // Bar index from next horizontal position; blank outside active area
    always_comb begin
        bar_idx_c = BAR_IDX_W'(h_next / COUNT_W'(BAR_W));
        rgb_d     = de_d ? bar_colour(bar_idx_c) : BAR_BLACK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q <= BAR_BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_out  = rgb_q;
    assign unused_c = ^v_next;
`else
    assign rgb_out  = '0;
    assign unused_c = ^{h_next, v_next};
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a small raster.
// A reference model predicts every cycle's outputs into a scoreboard queue;
// a table of hand-derived vectors and a few sequences add direct checks.
module tb_video_timing_gen;

`ifdef VTG_TEST_PATTERN_EN
    localparam int H_ACT = 8;
`else
    localparam int H_ACT = 4;
`endif
    localparam int H_FP  = 1;
    localparam int H_SY  = 2;
    localparam int H_BP  = 1;
    localparam int V_ACT = 3;
    localparam int V_FP  = 1;
    localparam int V_SY  = 1;
    localparam int V_BP  = 1;
    localparam int HT    = H_ACT + H_FP + H_SY + H_BP;
    localparam int VT    = V_ACT + V_FP + V_SY + V_BP;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } obs_t;

    typedef struct {
        logic rst;
        logic tick;
        int   h;
        int   v;
        logic de;
        logic ls;
        logic fs;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        tick_in;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
    logic        line_start_out;
    logic        frame_start_out;
    logic [23:0] rgb_out;

    int    errors;
    int    checks;
    int    mh;
    int    mv;
    string phase;
    obs_t  sb[$];
    logic [23:0] bars [8];

    video_timing_gen #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .SYNC_POL (1'b0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .tick_in         (tick_in),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .de_out          (de_out),
        .line_start_out  (line_start_out),
        .frame_start_out (frame_start_out),
        .rgb_out         (rgb_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected observation for a model position
    function automatic obs_t model_obs(input int h, input int v, input logic ls, input logic fs);
        obs_t o;
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.de  = (h < H_ACT) && (v < V_ACT);
        o.hs  = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY));
        o.vs  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY));
        o.ls  = ls;
        o.fs  = fs;
        o.rgb = 24'h0;
`ifdef VTG_TEST_PATTERN_EN
        if (o.de) o.rgb = bars[h / (H_ACT / 8)];
`endif
        return o;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Pop the prediction for this cycle and compare with the DUT
    task automatic check_sb();
        obs_t e;
        obs_t a;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", phase);
            return;
        end
        e = sb.pop_front();
        a = '{h: hcount_out, v: vcount_out, de: de_out, hs: hsync_out, vs: vsync_out,
              ls: line_start_out, fs: frame_start_out, rgb: rgb_out};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h, want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h",
                     phase, a.h, a.v, a.de, a.hs, a.vs, a.ls, a.fs, a.rgb,
                     e.h, e.v, e.de, e.hs, e.vs, e.ls, e.fs, e.rgb);
        end
    endtask

    // Drive one clock of stimulus, predict, then compare after the edge
    task automatic step(input logic r, input logic t);
        logic ls;
        logic fs;
        ls = 1'b0;
        fs = 1'b0;
        reset   = r;
        tick_in = t;
        if (r) begin
            mh = HT - 1;
            mv = VT - 1;
        end else if (t) begin
            ls = (mh == HT - 1);
            fs = ls && (mv == VT - 1);
            if (ls) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        sb.push_back(model_obs(mh, mv, ls, fs));
        @(posedge clock);
        #1;
        check_sb();
    endtask

    initial begin
        vec_t vecs [8];
        int   de_cnt;
        int   hs_cnt;
        int   vs_cnt;
        int   tick_no;
        int   last_fs;
        int   guard;

        errors  = 0;
        checks  = 0;
        mh      = HT - 1;
        mv      = VT - 1;
        reset   = 1'b1;
        tick_in = 1'b0;
        bars    = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

        vecs[0] = '{rst: 1'b1, tick: 1'b0, h: HT - 1, v: VT - 1, de: 1'b0, ls: 1'b0, fs: 1'b0};
        vecs[1] = '{rst: 1'b1, tick: 1'b1, h: HT - 1, v: VT - 1, de: 1'b0, ls: 1'b0, fs: 1'b0};
        vecs[2] = '{rst: 1'b0, tick: 1'b0, h: HT - 1, v: VT - 1, de: 1'b0, ls: 1'b0, fs: 1'b0};
        vecs[3] = '{rst: 1'b0, tick: 1'b1, h: 0,      v: 0,      de: 1'b1, ls: 1'b1, fs: 1'b1};
        vecs[4] = '{rst: 1'b0, tick: 1'b0, h: 0,      v: 0,      de: 1'b1, ls: 1'b0, fs: 1'b0};
        vecs[5] = '{rst: 1'b0, tick: 1'b1, h: 1,      v: 0,      de: 1'b1, ls: 1'b0, fs: 1'b0};
        vecs[6] = '{rst: 1'b0, tick: 1'b1, h: 2,      v: 0,      de: 1'b1, ls: 1'b0, fs: 1'b0};
        vecs[7] = '{rst: 1'b0, tick: 1'b1, h: 3,      v: 0,      de: 1'b1, ls: 1'b0, fs: 1'b0};

        // Reset then a long idle stretch: state parked, strobes quiet
        phase = "reset_idle";
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        check_val("idle_hsync", int'(hsync_out), 1);
        check_val("idle_vsync", int'(vsync_out), 1);

        // Hand-derived vectors: reset dominance, first tick, hold, advance
        phase = "table";
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rst, vecs[i].tick);
            check_val($sformatf("vec%0d_h", i), int'(hcount_out), vecs[i].h);
            check_val($sformatf("vec%0d_v", i), int'(vcount_out), vecs[i].v);
            check_val($sformatf("vec%0d_de", i), int'(de_out), int'(vecs[i].de));
            check_val($sformatf("vec%0d_ls", i), int'(line_start_out), int'(vecs[i].ls));
            check_val($sformatf("vec%0d_fs", i), int'(frame_start_out), int'(vecs[i].fs));
        end

        // Continuous ticks over three frames; census of one full frame
        phase   = "continuous";
        de_cnt  = 0;
        hs_cnt  = 0;
        vs_cnt  = 0;
        last_fs = -1;
        for (tick_no = 0; tick_no < 3 * HT * VT; tick_no++) begin
            step(1'b0, 1'b1);
            if (tick_no < HT * VT) begin
                de_cnt += int'(de_out);
                hs_cnt += int'(!hsync_out);
                vs_cnt += int'(!vsync_out);
            end
            if (frame_start_out) begin
                if (last_fs >= 0) check_val("frame_period", tick_no - last_fs, HT * VT);
                last_fs = tick_no;
            end
        end
        check_val("de_per_frame", de_cnt, H_ACT * V_ACT);
        check_val("hsync_per_frame", hs_cnt, H_SY * VT);
        check_val("vsync_per_frame", vs_cnt, V_SY * HT);

        // Sparse ticks: every 5th clock, outputs move only after a tick
        phase = "sparse";
        for (int i = 0; i < 5 * HT * VT + 3; i++) step(1'b0, (i % 5) == 0);

        // Advance to (2,1) then reset coincident with a tick
        phase = "seek";
        guard = 0;
        while (!(mh == 2 && mv == 1) && guard < 2 * HT * VT) begin
            step(1'b0, 1'b1);
            guard++;
        end
        check_val("seek_h", int'(hcount_out), 2);
        check_val("seek_v", int'(vcount_out), 1);
        phase = "mid_reset";
        step(1'b1, 1'b1);
        check_val("midrst_h", int'(hcount_out), HT - 1);
        check_val("midrst_v", int'(vcount_out), VT - 1);
        check_val("midrst_de", int'(de_out), 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_val("post_rst_fs", int'(frame_start_out), 1);
        step(1'b0, 1'b0);
        check_val("post_rst_fs_clear", int'(frame_start_out), 0);

        // One more line of back-to-back ticks across the first active line
        phase = "line";
        for (int i = 0; i < HT; i++) step(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the HDMI transmit path. Sits directly downstream of the pixel-rate prescale counter: consumes its one-cycle terminal-count pulse as a pixel tick and, on each tick, advances horizontal/vertical position, producing registered hsync, vsync, data-enable, coordinates and frame/line start strobes for the encoder stage. Optional colour-bar pattern output for bring-up.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level for both hsync/vsync (0 = active-low)
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- tick_in  in  1  pixel tick, one clock wide (prescale counter terminal count)
- hcount_out  out  11  current horizontal position, 0..H_TOTAL-1
- vcount_out  out  11  current vertical position, 0..V_TOTAL-1
- hsync_out  out  1  horizontal sync, level per SYNC_POL
- vsync_out  out  1  vertical sync, level per SYNC_POL
- de_out  out  1  high while position is in active area
- line_start_out  out  1  one-clock strobe when hcount_out becomes 0
- frame_start_out  out  1  one-clock strobe when position becomes (0,0)
- rgb_out  out  24  pixel colour {R,G,B}, 8 bits each

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both ≤ 2048 (11-bit counts). Per-line order: active, front porch, sync, back porch; same vertically.
- On tick_in=1: hcount advances by 1; at H_TOTAL-1 it wraps to 0 and vcount advances by 1; vcount at V_TOTAL-1 wraps to 0 on the same tick. tick_in=0: all state holds.
- hsync active iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC; vsync active iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (line-granular, changes with vcount at hcount wrap).
- de_out = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- All decodes computed from the next position and registered alongside the counters, so every output always describes hcount_out/vcount_out of the same cycle.
- Reset: hcount_out = H_TOTAL-1, vcount_out = V_TOTAL-1, de_out = 0, hsync_out = vsync_out = !SYNC_POL (inactive), strobes 0, rgb_out = 0. First tick after reset lands on (0,0) with de_out=1, line_start_out=1, frame_start_out=1.
- Reset asserted mid-frame returns immediately to the reset state; reset dominates a coincident tick.
- Back-to-back ticks (tick_in held high) are legal: position advances every clock.

## Timing
- Latency: outputs change in the clock cycle after the rising edge sampling tick_in=1; no further pipeline.
- Strobes: high for exactly one clock cycle, in that same cycle; low otherwise, even while position holds.
- Outputs stable between ticks.

## Configuration
- VTG_TEST_PATTERN_EN defined: rgb_out drives 8 vertical colour bars across active width, bar = hcount/(H_ACTIVE/8), order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000; rgb_out = 0 where de_out=0; registered in step with de_out. H_ACTIVE must be a multiple of 8.
- Undefined: rgb_out tied to 0; no bar logic.

## Structure
- Package vtg_pkg: default timing constants (640x480@60), count width (11), colour-bar constants, H_TOTAL/V_TOTAL helper function.
- Sub-module vtg_axis_counter: one axis counter with advance input, wrap output, and active/sync region decode; instantiated twice (horizontal advanced by tick_in, vertical by horizontal wrap && tick_in).

## Test plan
Small bench parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), SYNC_POL=0.
- Reset, no ticks for 20 clocks -> hcount=7, vcount=5, de=0, hsync=vsync=1, strobes never high.
- First tick after reset -> next cycle hcount=0, vcount=0, de=1, line_start=1, frame_start=1; both strobes 0 following cycle.
- Continuous ticks over one frame -> de high for hcount 0..3 on vcount 0..2 only; hsync=0 exactly at hcount 5,6; vsync=0 for all of vcount 4; frame_start every 48 ticks.
- Ticks every 5th clock -> outputs change only in cycle after each tick; counts identical to continuous case per tick.
- Reset at (hcount=2, vcount=1) coincident with tick -> reset state next cycle, tick ignored.
- VTG_TEST_PATTERN_EN, H_ACTIVE=8 -> rgb_out at hcount 0..7 of active line = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; 0 during blanking.
